// File: rtl/sad_pkg.sv
// Shared constants and FSM state type for the SAD operand loader.
package sad_pkg;
  localparam int NPAIRS     = 8;
  localparam int DW         = 32;
  localparam int AW         = 32;
  localparam int WORD_BYTES = 4;
  localparam int IDX_W      = 4;
  localparam int SLOT_W     = 3;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_VALID} stateT;
endpackage

// File: rtl/sad_operand_loader_if.sv
// Memory data port plus operand-set handshake between the loader and its neighbours.
interface sad_operand_loader_if;
  import sad_pkg::*;

  // Handshakes: a memory word transfers on any cycle with MemRead && MemReady;
  // an operand set transfers on a cycle with OpValid && OpAccept. OpValid, once
  // raised, holds with stable OpA/OpB/DstOut until the transfer (or a Flush).
  logic                 Start;
  logic [AW-1:0]        BaseA;
  logic [AW-1:0]        BaseB;
  logic [4:0]           DstIn;
  logic                 Flush;
  logic                 MemRead;
  logic [AW-1:0]        MemAddr;
  logic [DW-1:0]        MemReadData;
  logic                 MemReady;
  logic [NPAIRS*DW-1:0] OpA;
  logic [NPAIRS*DW-1:0] OpB;
  logic [4:0]           DstOut;
  logic                 OpValid;
  logic                 OpAccept;
  logic                 Busy;
  stateT                DbgState;

  modport master (
    input  Start, BaseA, BaseB, DstIn, Flush, MemReadData, MemReady, OpAccept,
    output MemRead, MemAddr, OpA, OpB, DstOut, OpValid, Busy, DbgState
  );

  modport slave (
    output Start, BaseA, BaseB, DstIn, Flush, MemReadData, MemReady, OpAccept,
    input  MemRead, MemAddr, OpA, OpB, DstOut, OpValid, Busy, DbgState
  );
endinterface

// File: rtl/sad_addr_gen.sv
// Maps a load index onto a word address and the A/B bank slot it fills.
module sad_addr_gen
  import sad_pkg::*;
(
  input  logic [IDX_W-1:0]  idx,
  input  logic [AW-1:0]     baseA,
  input  logic [AW-1:0]     baseB,
  output logic [AW-1:0]     memAddr,
  output logic              selB,
  output logic [SLOT_W-1:0] slot
);
  logic [AW-1:0] offset;

  // Upper half of the index walks the B window; sum wraps modulo 2^AW.
  always_comb begin
    selB    = idx[IDX_W-1];
    slot    = idx[SLOT_W-1:0];
    offset  = AW'({slot, 2'b00});
    memAddr = (selB ? baseB : baseA) + offset;
  end
endmodule

// File: rtl/sad_operand_loader.sv
// Gathers NPAIRS A words then NPAIRS B words from memory and offers them as one operand set.
module sad_operand_loader
  import sad_pkg::*;
(
  input logic           Clk,
  input logic           Reset,
  sad_operand_loader_if.master bus
);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(2*NPAIRS-1);
  localparam logic [AW-1:0]    ALIGN_MASK = ~AW'(WORD_BYTES-1);

  stateT                state, nextState;
  logic [IDX_W-1:0]     idx;
  logic [AW-1:0]        baseA, baseB, addr;
  logic                 selB;
  logic [SLOT_W-1:0]    slot;
  logic [NPAIRS*DW-1:0] opA, opB;
  logic [4:0]           dstOut;
  logic                 startLoad, capture;

  sad_addr_gen u_addr_gen (
    .idx     (idx),
    .baseA   (baseA),
    .baseB   (baseB),
    .memAddr (addr),
    .selB    (selB),
    .slot    (slot)
  );

  always_comb begin
    nextState = state;
    startLoad = 1'b0;
    capture   = 1'b0;
    if (bus.Flush) begin
      nextState = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.Start) begin
            nextState = S_LOAD;
            startLoad = 1'b1;
          end
        end
        S_LOAD: begin
          if (bus.MemReady) begin
            capture = 1'b1;
            if (idx == LAST_IDX) nextState = S_VALID;
          end
        end
        S_VALID: begin
          // Accept with Start reloads immediately so there is no idle bubble.
          if (bus.OpAccept) begin
            if (bus.Start) begin
              nextState = S_LOAD;
              startLoad = 1'b1;
            end else begin
              nextState = S_IDLE;
            end
          end
        end
        default: nextState = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state  <= S_IDLE;
      idx    <= '0;
      baseA  <= '0;
      baseB  <= '0;
      opA    <= '0;
      opB    <= '0;
      dstOut <= '0;
    end else begin
      state <= nextState;
      if (bus.Flush) begin
        idx <= '0;
      end else if (startLoad) begin
        idx    <= '0;
        baseA  <= bus.BaseA & ALIGN_MASK;
        baseB  <= bus.BaseB & ALIGN_MASK;
        dstOut <= bus.DstIn;
      end else if (capture) begin
        idx <= idx + 1'b1;
        if (selB) opB[slot*DW +: DW] <= bus.MemReadData;
        else      opA[slot*DW +: DW] <= bus.MemReadData;
      end
    end
  end

  assign bus.MemRead  = (state == S_LOAD);
  assign bus.OpValid  = (state == S_VALID);
  assign bus.Busy     = (state != S_IDLE);
  assign bus.MemAddr  = addr;
  assign bus.OpA      = opA;
  assign bus.OpB      = opB;
  assign bus.DstOut   = dstOut;
  assign bus.DbgState = state;
endmodule
